assemble_scheduler: RTL
=======================

# assemble_scheduler

Sequencer that drives the tag/valid/tlast inputs of the assemble-phase assembler. It accepts multi-category beat groups from the upstream pipeline over a valid/ready handshake. Each accepted beat is stamped with a tag from a programmable pattern table, which cycles per beat and restarts at each frame. The block counts beats and frames, marks frame ends with tlast, and throttles on a downstream almost-full signal, because the assembler itself has no backpressure.

## Interface
- DATA_WIDTH, 16, width of one category data word
- TAG_WIDTH, 8, tag width (matches assembler)
- TAG_CATAGORY, 4, number of data words per beat group
- PAT_DEPTH, 16, pattern table entries (power of 2)
- LEN_WIDTH, 16, width of beat/frame counters
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_we  in  1  pattern table write strobe (ignored while busy_o)
- cfg_addr  in  $clog2(PAT_DEPTH)  table write address
- cfg_tag  in  TAG_WIDTH  tag value written
- cfg_pat_len  in  $clog2(PAT_DEPTH)+1  used table entries; latched at start
- cfg_frame_len  in  LEN_WIDTH  beats per frame; latched at start
- cfg_frame_num  in  LEN_WIDTH  frames per run; latched at start
- start_i  in  1  run start pulse (accepted in IDLE only)
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse at run completion
- tag_oob_o  out  1  sticky: a tag >= TAG_CATAGORY was issued this run
- s_data  in  [TAG_CATAGORY-1:0][DATA_WIDTH-1:0]  upstream beat group
- s_valid  in  1  upstream valid
- s_ready  out  1  upstream ready
- asm_ready_i  in  1  sink can take at least 2 more beats
- tag_o  out  TAG_WIDTH  to assembler tag_i
- data_o  out  [TAG_CATAGORY-1:0][DATA_WIDTH-1:0]  to assembler data_i
- tlast_o  out  1  to assembler tlast_i
- vld_o  out  1  to assembler vld_i

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start_i. Latches lengths; a latched value of 0 is treated as 1. Clears beat_cnt, frame_cnt, pat_idx and tag_oob_o.
  - RUN -> DONE on the handshake carrying the last beat of the last frame.
  - DONE -> IDLE unconditionally after one cycle.
- s_ready = (state==RUN) && asm_ready_i. A handshake is s_valid && s_ready.
- Per handshake:
  - Output registers load tag_o = pat[pat_idx], data_o = s_data, vld_o = 1.
  - tlast_o = (beat_cnt == frame_len-1).
- pat_idx increments and wraps to 0 after pat_len-1. It also resets to 0 at every frame end, so every frame starts at pat[0].
- beat_cnt wraps to 0 at frame end, and frame_cnt then increments.
- vld_o = 0 in any cycle without a handshake in the previous cycle. tag_o, data_o and tlast_o hold their values; tlast_o is 0 when vld_o is 0.
- tag_oob_o is set when an issued tag >= TAG_CATAGORY. The tag is passed through unchanged (the assembler then selects category 0).
- Pattern table:
  - cfg_we is honoured only when busy_o = 0.
  - Table entries reset to 0.
  - cfg_pat_len > PAT_DEPTH is clamped to PAT_DEPTH.
- busy_o = (state != IDLE). done_o = (state == DONE).
- start_i in RUN or DONE is ignored.
- Reset mid-run:
  - State returns to IDLE; all counters clear.
  - vld_o, tlast_o, busy_o, done_o and tag_oob_o go to 0; tag_o and data_o reset to 0.
  - No partial frame completion is emitted.

## Timing
- Start accepted at cycle t: busy_o = 1 at t+1, s_ready may be 1 at t+1.
- Handshake at cycle k: vld_o/tag_o/tlast_o valid at k+1; assembler output at k+2.
- Final handshake at k: DONE at k+1. done_o pulses at k+1, coincident with the final vld_o/tlast_o. busy_o falls at k+2.
- The earliest next start is accepted at k+2.
- asm_ready_i deasserts combinationally gate s_ready. At most 2 beats (one in the scheduler, one in the assembler) arrive after the sink deasserts.
- Full throughput: one beat per cycle while s_valid and asm_ready_i stay high.

## Test plan
- Program pattern [2,0,3], pat_len=3, frame_len=7, frame_num=1, continuous s_valid -> tags 2,0,3,2,0,3,2; tlast on beat 7 only; done_o on the same cycle as that vld_o.
- pat_len=4, frame_len=3, frame_num=2 -> frame tags 0,1,2 then 0,1,2 (pattern restarts per frame); tlast on beats 3 and 6; busy_o low 2 cycles after last handshake.
- Toggle asm_ready_i low for 5 cycles mid-frame -> s_ready low, no vld_o gaps beyond the stall, beat/tag order preserved, no beats lost.
- Write tag 9 with TAG_CATAGORY=4 -> tag_oob_o sets on first issue and stays set until the next start.
- Zero lengths (pat_len=0, frame_len=0, frame_num=0) -> single beat, tag pat[0], tlast=1, done_o.
- Assert rst_n low mid-frame, then start a new run -> vld_o/busy_o drop next cycle, table reads 0; new run's first tag = pat[0] with beat_cnt from 0; cfg_we and start_i during busy have no effect.

Source files
------------

// File: rtl/assemble_scheduler_if.sv
// Stream bundle between the upstream pipeline, the scheduler and the assembler.
// s_valid/s_ready: a beat transfers on every rising clk edge where both are high; vld_o is a push with no backpressure.
interface assemble_scheduler_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int TAG_WIDTH    = 8,
  parameter int TAG_CATAGORY = 4
);
  logic [TAG_CATAGORY-1:0][DATA_WIDTH-1:0] s_data;
  logic                                    s_valid;
  logic                                    s_ready;
  logic                                    asm_ready_i;
  logic [TAG_WIDTH-1:0]                    tag_o;
  logic [TAG_CATAGORY-1:0][DATA_WIDTH-1:0] data_o;
  logic                                    tlast_o;
  logic                                    vld_o;

  modport slave (
    input  s_data, s_valid, asm_ready_i,
    output s_ready, tag_o, data_o, tlast_o, vld_o
  );

  modport master (
    output s_data, s_valid, asm_ready_i,
    input  s_ready, tag_o, data_o, tlast_o, vld_o
  );
endinterface

// File: rtl/assemble_scheduler.sv
// Beat sequencer for the assembler: stamps accepted beats with tags from a pattern table,
// counts beats/frames, marks frame ends and throttles on the sink's almost-full.
module assemble_scheduler #(
  parameter int DATA_WIDTH   = 16,
  parameter int TAG_WIDTH    = 8,
  parameter int TAG_CATAGORY = 4,
  parameter int PAT_DEPTH    = 16,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_we,
  input  logic [$clog2(PAT_DEPTH)-1:0] cfg_addr,
  input  logic [TAG_WIDTH-1:0]         cfg_tag,
  input  logic [$clog2(PAT_DEPTH):0]   cfg_pat_len,
  input  logic [LEN_WIDTH-1:0]         cfg_frame_len,
  input  logic [LEN_WIDTH-1:0]         cfg_frame_num,
  input  logic                         start_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         tag_oob_o,
  output logic [1:0]                   state_dbg,
  assemble_scheduler_if.slave          bus
);
  localparam int AW = $clog2(PAT_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [TAG_WIDTH-1:0] pat_mem [PAT_DEPTH];
  logic [AW:0]          pat_len_q;
  logic [LEN_WIDTH-1:0] frame_len_q, frame_num_q;
  logic [LEN_WIDTH-1:0] beat_cnt, frame_cnt;
  logic [AW-1:0]        pat_idx;

  logic [TAG_WIDTH-1:0]                    tag_q;
  logic [TAG_CATAGORY-1:0][DATA_WIDTH-1:0] data_q;
  logic                                    tlast_q, vld_q, oob_q;

  logic                 s_ready, hs, last_beat, last_frame, pat_wrap, start_ok;
  logic [TAG_WIDTH-1:0] pat_rd;
  logic [AW:0]          pat_len_eff;
  logic [LEN_WIDTH-1:0] frame_len_eff, frame_num_eff;

  assign start_ok   = (state_q == S_IDLE) && start_i;
  assign s_ready    = (state_q == S_RUN) && bus.asm_ready_i;
  assign hs         = bus.s_valid && s_ready;
  assign last_beat  = (beat_cnt == frame_len_q - LEN_WIDTH'(1));
  assign last_frame = (frame_cnt == frame_num_q - LEN_WIDTH'(1));
  assign pat_wrap   = (({1'b0, pat_idx} + (AW+1)'(1)) == pat_len_q);
  assign pat_rd     = pat_mem[pat_idx];

  // Zero lengths run as one; pattern lengths beyond the table use the whole table.
  assign pat_len_eff   = (cfg_pat_len == '0) ? (AW+1)'(1) :
                         (cfg_pat_len > (AW+1)'(PAT_DEPTH)) ? (AW+1)'(PAT_DEPTH) : cfg_pat_len;
  assign frame_len_eff = (cfg_frame_len == '0) ? LEN_WIDTH'(1) : cfg_frame_len;
  assign frame_num_eff = (cfg_frame_num == '0) ? LEN_WIDTH'(1) : cfg_frame_num;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (hs && last_beat && last_frame) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PAT_DEPTH; i++) pat_mem[i] <= '0;
      pat_len_q   <= (AW+1)'(1);
      frame_len_q <= LEN_WIDTH'(1);
      frame_num_q <= LEN_WIDTH'(1);
      beat_cnt    <= '0;
      frame_cnt   <= '0;
      pat_idx     <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      tlast_q     <= 1'b0;
      vld_q       <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      vld_q   <= hs;
      tlast_q <= hs && last_beat;
      if (cfg_we && (state_q == S_IDLE)) pat_mem[cfg_addr] <= cfg_tag;
      if (start_ok) begin
        pat_len_q   <= pat_len_eff;
        frame_len_q <= frame_len_eff;
        frame_num_q <= frame_num_eff;
        beat_cnt    <= '0;
        frame_cnt   <= '0;
        pat_idx     <= '0;
        oob_q       <= 1'b0;
      end
      if (hs) begin
        tag_q  <= pat_rd;
        data_q <= bus.s_data;
        // Out-of-range tags still go out; the assembler falls back to category 0.
        if (pat_rd >= TAG_WIDTH'(TAG_CATAGORY)) oob_q <= 1'b1;
        if (last_beat) begin
          beat_cnt  <= '0;
          frame_cnt <= frame_cnt + LEN_WIDTH'(1);
          pat_idx   <= '0;
        end else begin
          beat_cnt <= beat_cnt + LEN_WIDTH'(1);
          pat_idx  <= pat_wrap ? '0 : pat_idx + AW'(1);
        end
      end
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.tag_o   = tag_q;
  assign bus.data_o  = data_q;
  assign bus.tlast_o = tlast_q;
  assign bus.vld_o   = vld_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign tag_oob_o   = oob_q;
  assign state_dbg   = state_q;
endmodule
